// File: rtl/branch_history_table.sv
// Branch direction predictor: PC-indexed table of 2-bit saturating counters with a
// one-deep registered update stage, so training becomes visible two cycles after it is presented.
module branch_history_table #(
  parameter int unsigned VLEN       = 64,
  parameter int unsigned NR_ENTRIES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  output logic            bht_valid_o,
  output logic            bht_taken_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  // Updates carry no handshake: a resolved branch is accepted in the cycle
  // upd_valid_i is high, and there is never backpressure.

  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]            cnt_q [NR_ENTRIES];
  logic [1:0]            cnt_d [NR_ENTRIES];

  logic                  upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]      upd_idx_q, upd_idx_d;
  logic                  upd_taken_q, upd_taken_d;

  logic [IDX_W-1:0]      vpc_idx;
  logic [1:0]            cur_cnt;

  // Index is halfword granular so compressed branches get their own entries.
  assign vpc_idx = vpc_i[IDX_W:1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0],
                            upd_pc_i[VLEN-1:IDX_W+1], upd_pc_i[0]};

  assign bht_valid_o = valid_q[vpc_idx];
  assign bht_taken_o = valid_q[vpc_idx] & cnt_q[vpc_idx][1];

  always_comb begin
    upd_valid_d = upd_valid_i & ~debug_mode_i & ~flush_bp_i;
    upd_idx_d   = upd_pc_i[IDX_W:1];
    upd_taken_d = upd_taken_i;
  end

  // The write stage reads and writes the same entry in one cycle, so
  // back-to-back updates to one index chain without forwarding.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    cur_cnt = cnt_q[upd_idx_q];
    if (flush_bp_i) begin
      valid_d = '0;
    end else if (upd_valid_q) begin
      valid_d[upd_idx_q] = 1'b1;
      if (!valid_q[upd_idx_q]) begin
        cnt_d[upd_idx_q] = upd_taken_q ? 2'b10 : 2'b01;
      end else if (upd_taken_q && (cur_cnt != 2'b11)) begin
        cnt_d[upd_idx_q] = cur_cnt + 2'd1;
      end else if (!upd_taken_q && (cur_cnt != 2'b00)) begin
        cnt_d[upd_idx_q] = cur_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      cnt_q       <= '{default: 2'b00};
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed scenarios with hand-derived expectations,
// then a random phase checked against a reference table.
module tb_branch_history_table;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_bp_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [63:0] vpc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [63:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic        bht_valid_o;
  logic        bht_taken_o;

  branch_history_table #(.VLEN(64), .NR_ENTRIES(1024)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_bp_i   (flush_bp_i),
    .debug_mode_i (debug_mode_i),
    .vpc_i        (vpc_i),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .bht_valid_o  (bht_valid_o),
    .bht_taken_o  (bht_taken_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got valid,taken=%b required %b at %0t", tag, got, exp, $time);
  endtask

  // Reference table: the two-stage update behaviour written out directly.
  bit         m_valid [1024];
  logic [1:0] m_cnt   [1024];
  bit         m_pv;
  logic [9:0] m_pidx;
  bit         m_pt;

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 2'b00;
    end
    m_pv = 1'b0; m_pidx = '0; m_pt = 1'b0;
  endtask

  task automatic model_edge(input logic uv, input logic [63:0] upc, input logic ut,
                            input logic fl, input logic dbg);
    if (fl) begin
      for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    end else if (m_pv) begin
      if (!m_valid[m_pidx]) m_cnt[m_pidx] = m_pt ? 2'b10 : 2'b01;
      else if (m_pt && m_cnt[m_pidx] != 2'b11) m_cnt[m_pidx] = m_cnt[m_pidx] + 2'd1;
      else if (!m_pt && m_cnt[m_pidx] != 2'b00) m_cnt[m_pidx] = m_cnt[m_pidx] - 2'd1;
      m_valid[m_pidx] = 1'b1;
    end
    m_pv   = uv && !dbg && !fl;
    m_pidx = upc[10:1];
    m_pt   = ut;
  endtask

  function automatic logic [1:0] model_lookup(input logic [63:0] pc);
    logic [9:0] ix;
    ix = pc[10:1];
    return {m_valid[ix], m_valid[ix] & m_cnt[ix][1]};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one cycle, compares at the falling edge.
  task automatic step(input logic [63:0] vpc, input logic uv, input logic [63:0] upc,
                      input logic ut, input logic fl, input logic dbg,
                      input logic chk, input logic [1:0] exp, input string tag);
    vpc_i = vpc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    flush_bp_i = fl; debug_mode_i = dbg;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge clk_i);
    if (chk) check_eq(tag_q.pop_front(), {bht_valid_o, bht_taken_o}, exp_q.pop_front());
    @(posedge clk_i);
    model_edge(uv, upc, ut, fl, dbg);
    #1;
  endtask

  task automatic look(input logic [63:0] vpc, input logic [1:0] exp, input string tag);
    step(vpc, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, exp, tag);
  endtask

  task automatic train(input logic [63:0] upc, input logic ut, input logic [63:0] vpc,
                       input logic [1:0] exp, input string tag);
    step(vpc, 1'b1, upc, ut, 1'b0, 1'b0, 1'b1, exp, tag);
  endtask

  task automatic do_reset(input logic [63:0] vpc);
    rst_ni = 1'b0;
    upd_valid_i = 1'b0; flush_bp_i = 1'b0; debug_mode_i = 1'b0; vpc_i = vpc;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("in_reset", {bht_valid_o, bht_taken_o}, 2'b00);
    end
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0] PC_A = 64'h0000_0000_8000_0010;

  initial begin
    logic [63:0] rp, rv;
    logic        ruv, rut, rfl, rdbg;

    do_reset(64'h0);

    // Reset state sweep over every index.
    for (int i = 0; i < 1024; i++) look(64'(i * 2), 2'b00, "reset_sweep");

    // First training: visible two cycles later as cnt=2.
    train(PC_A, 1'b1, PC_A, 2'b00, "t2_cycleN");
    look(PC_A, 2'b00, "t2_cycleN1");
    look(PC_A, 2'b11, "t2_cycleN2");

    // Saturate up, walk down, saturate at 0, then step back up.
    train(PC_A, 1'b1, PC_A, 2'b11, "t3_up_a");
    train(PC_A, 1'b1, PC_A, 2'b11, "t3_up_b");
    look(PC_A, 2'b11, "t3_cnt3");
    train(PC_A, 1'b0, PC_A, 2'b11, "t3_nt1");
    look(PC_A, 2'b11, "t3_nt1_wait");
    look(PC_A, 2'b11, "t3_cnt2");
    train(PC_A, 1'b0, PC_A, 2'b11, "t3_nt2");
    train(PC_A, 1'b0, PC_A, 2'b11, "t3_nt3");
    look(PC_A, 2'b10, "t3_cnt1");
    look(PC_A, 2'b10, "t3_cnt0");
    train(PC_A, 1'b0, PC_A, 2'b10, "t3_nt4");
    look(PC_A, 2'b10, "t3_nt4_wait");
    look(PC_A, 2'b10, "t3_sat0");
    train(PC_A, 1'b1, PC_A, 2'b10, "t3_tk_from0");
    look(PC_A, 2'b10, "t3_tk_wait");
    look(PC_A, 2'b10, "t3_cnt1_again");
    train(PC_A, 1'b1, PC_A, 2'b10, "t3_tk2");
    look(PC_A, 2'b10, "t3_tk2_wait");
    look(PC_A, 2'b11, "t3_cnt2_again");

    // Clear the table so the aliasing check starts from an invalid entry.
    step(PC_A, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, "flush_edge");
    look(PC_A, 2'b00, "flush_cleared");

    // Aliasing: 0x10 and 0x810 share index 0x008.
    train(64'h10, 1'b0, 64'h810, 2'b00, "t4_train");
    look(64'h810, 2'b00, "t4_wait");
    look(64'h810, 2'b10, "t4_alias_read");
    train(64'h810, 1'b1, 64'h10, 2'b10, "t4_train_alias");
    look(64'h10, 2'b10, "t4_wait2");
    look(64'h10, 2'b11, "t4_alias_cnt2");

    // Flush one cycle after an update drops it and clears all entries.
    train(64'h20, 1'b1, 64'h20, 2'b00, "t5_upd");
    step(64'h20, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "t5_flush");
    look(64'h20, 2'b00, "t5_dropped");
    look(64'h20, 2'b00, "t5_dropped_late");
    look(64'h10, 2'b00, "t5_old_cleared");
    // Update presented together with flush is not captured.
    step(64'h30, 1'b1, 64'h30, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, "t5_upd_with_flush");
    look(64'h30, 2'b00, "t5_uwf_wait");
    look(64'h30, 2'b00, "t5_uwf_dropped");

    // Debug mode discards training.
    step(64'h40, 1'b1, 64'h40, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, "t6_dbg_upd");
    look(64'h40, 2'b00, "t6_dbg_wait");
    look(64'h40, 2'b00, "t6_dbg_dropped");

    // Reset one cycle after an update discards it and the table.
    train(64'h40, 1'b1, 64'h40, 2'b00, "t6_upd40");
    look(64'h40, 2'b00, "t6_wait40");
    look(64'h40, 2'b11, "t6_valid40");
    train(64'h50, 1'b1, 64'h50, 2'b00, "t6_upd50");
    do_reset(64'h40);
    look(64'h50, 2'b00, "t6_pending_lost");
    look(64'h40, 2'b00, "t6_table_lost");
    look(64'h50, 2'b00, "t6_pending_lost2");

    // Random phase over a few colliding indices.
    for (int n = 0; n < 400; n++) begin
      rp   = 64'($urandom_range(0, 7)) << 1;
      if ($urandom_range(0, 1) == 1) rp = rp | 64'h800;
      rv   = 64'($urandom_range(0, 7)) << 1;
      ruv  = ($urandom_range(0, 2) != 0);
      rut  = ($urandom_range(0, 1) == 1);
      rfl  = ($urandom_range(0, 24) == 0);
      rdbg = ($urandom_range(0, 9) == 0);
      step(rv, ruv, rp, rut, rfl, rdbg, 1'b1, model_lookup(rv), "rand");
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
